// File: rtl/note_cv_out.sv
// Monophonic note-to-CV output stage: maps a note to a fixed-point pitch code, optionally glides,
// and drives a first-order sigma-delta pair. The gate follows note on/off with an optional legato retrigger.
module note_cv_out #(
    parameter int CLK_DIV    = 50,
    parameter int NOTE_LO    = 0,
    parameter int NOTE_HI    = 59,
    parameter int RANGE_MODE = 0,
    parameter int CODE_W     = 6,
    parameter int FRAC_W     = 8,
    parameter int RETRIG     = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       note_valid,
    input  logic       note_on,
    input  logic [6:0] note_num,
    input  logic [6:0] velocity,
    input  logic       glide_en,
    input  logic [7:0] glide_rate,
    output logic       gate,
    output logic       busy,
    output logic       cv_p,
    output logic       cv_n
);

    localparam int PW    = CODE_W + FRAC_W;
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int RT_W  = (RETRIG > 0) ? $clog2(RETRIG + 1) : 1;
    localparam logic [7:0] NL = 8'(NOTE_LO);
    localparam logic [7:0] NH = 8'(NOTE_HI);

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [PW-1:0]    target, pitch;
    logic [PW-1:0]    target_nxt, pitch_nxt, glide_nxt, step;
    logic [PW:0]      acc, dsm_sum;
    logic [6:0]       held_note;
    logic [RT_W-1:0]  rt_cnt;
    logic [7:0]       m;
    logic             on_ev, off_hit, rt_active;

    assign on_ev     = note_valid & note_on & (velocity != 7'd0);
    assign rt_active = (rt_cnt != '0);
    // A note is still "held" while its retrigger gap is running, so a matching off cancels it.
    assign off_hit   = note_valid & ~on_ev & (note_num == held_note) & (gate | rt_active);

    always_comb begin
        m = {1'b0, note_num};
        if (RANGE_MODE != 0) begin
            for (int i = 0; i < 11; i++) begin
                if (m > NH)      m = m - 8'd12;
                else if (m < NL) m = m + 8'd12;
            end
        end else begin
            if (m < NL)      m = NL;
            else if (m > NH) m = NH;
        end
    end

    always_comb begin
        step      = PW'({1'b0, glide_rate} + 9'd1);
        glide_nxt = pitch;
        if (pitch < target)
            glide_nxt = (target - pitch <= step) ? target : pitch + step;
        else if (pitch > target)
            glide_nxt = (pitch - target <= step) ? target : pitch - step;
        pitch_nxt = pitch;
        if (tick) pitch_nxt = glide_en ? glide_nxt : target;
        target_nxt = target;
        if (on_ev) target_nxt = {CODE_W'(m - NL), {FRAC_W{1'b0}}};
    end

    assign dsm_sum = {1'b0, acc[PW-1:0]} + {1'b0, pitch};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick     <= (tick_cnt == CNT_W'(CLK_DIV - 1));
            tick_cnt <= (tick_cnt == CNT_W'(CLK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
        end
    end

    // Pitch and DSM both act on the pre-event target, so an event coincident with a tick lands next tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target <= '0;
            pitch  <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            cv_p   <= 1'b0;
            cv_n   <= 1'b1;
        end else begin
            target <= target_nxt;
            pitch  <= pitch_nxt;
            busy   <= (pitch_nxt != target_nxt);
            if (tick) begin
                acc  <= dsm_sum;
                cv_p <= dsm_sum[PW];
                cv_n <= ~dsm_sum[PW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate      <= 1'b0;
            rt_cnt    <= '0;
            held_note <= '0;
        end else if (on_ev) begin
            held_note <= note_num;
            if ((RETRIG > 0) && (gate || rt_active)) begin
                gate   <= 1'b0;
                rt_cnt <= RT_W'(RETRIG);
            end else begin
                gate   <= 1'b1;
            end
        end else if (off_hit) begin
            gate   <= 1'b0;
            rt_cnt <= '0;
        end else if (rt_active) begin
            rt_cnt <= rt_cnt - 1'b1;
            if (rt_cnt == RT_W'(1)) gate <= 1'b1;
        end
    end

endmodule

// File: tb/tb_note_cv_out.sv
// Randomised + directed bench for note_cv_out: a per-cycle reference model pushes expectations
// into a queue and a negedge monitor pops and compares them against the DUT.
module tb_note_cv_out;

    localparam int D      = 3;
    localparam int RT_LEN = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       note_valid = 1'b0;
    logic       note_on = 1'b0;
    logic [6:0] note_num = '0;
    logic [6:0] velocity = '0;
    logic       glide_en = 1'b0;
    logic [7:0] glide_rate = '0;
    logic       gate0, busy0, cvp0, cvn0;
    logic       gate1, busy1, cvp1, cvn1;
    logic       gate2, busy2, cvp2, cvn2;

    always #5 clk = ~clk;

    note_cv_out #(.CLK_DIV(D)) dut0 (
        .clk(clk), .reset_n(reset_n), .note_valid(note_valid), .note_on(note_on),
        .note_num(note_num), .velocity(velocity), .glide_en(glide_en), .glide_rate(glide_rate),
        .gate(gate0), .busy(busy0), .cv_p(cvp0), .cv_n(cvn0));
    note_cv_out #(.CLK_DIV(D), .RANGE_MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .note_valid(note_valid), .note_on(note_on),
        .note_num(note_num), .velocity(velocity), .glide_en(glide_en), .glide_rate(glide_rate),
        .gate(gate1), .busy(busy1), .cv_p(cvp1), .cv_n(cvn1));
    note_cv_out #(.CLK_DIV(D), .RANGE_MODE(1), .NOTE_LO(12)) dut2 (
        .clk(clk), .reset_n(reset_n), .note_valid(note_valid), .note_on(note_on),
        .note_num(note_num), .velocity(velocity), .glide_en(glide_en), .glide_rate(glide_rate),
        .gate(gate2), .busy(busy2), .cv_p(cvp2), .cv_n(cvn2));

    typedef struct {
        logic        gate, busy, cv;
        logic [13:0] pitch, target, t1, t2;
        bit          tick;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0;
    int   tick_seen = 0, hi_seen = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h @%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL timeout %s @%0t", nm, $time);
    endfunction

    // Clamp or octave-fold a note into [lo, hi] by direct arithmetic.
    function automatic int map_note(input int n, input int lo, input int hi, input int fold);
        if (fold == 0) return (n < lo) ? lo : ((n > hi) ? hi : n);
        if (n > hi) return n - 12 * ((n - hi + 11) / 12);
        if (n < lo) return n + 12 * ((lo - n + 11) / 12);
        return n;
    endfunction

    // Reference model: ticks are placed by cycle count since reset release; the DSM is the carry
    // of a running total of pitch, i.e. a change in floor(total / 2^14).
    int     k, mp, mt, mt1, mt2, rt_left, mheld;
    bit     held_act, mcv;
    longint tot;

    always @(posedge clk) begin : model
        exp_t   e;
        bit     tk, on;
        longint prev;
        int     st;
        if (!reset_n) begin
            k = 0; mp = 0; mt = 0; mt1 = 0; mt2 = 0; rt_left = 0; mheld = 0;
            held_act = 0; mcv = 0; tot = 0;
            q.delete();
        end else begin
            k++;
            tk = (k >= 2) && ((k - 1) % D == 0);
            if (tk) begin
                prev = tot;
                tot  = tot + mp;
                mcv  = (tot >> 14) != (prev >> 14);
                st   = int'(glide_rate) + 1;
                if (!glide_en)    mp = mt;
                else if (mp < mt) mp = (mp + st > mt) ? mt : mp + st;
                else if (mp > mt) mp = (mp - st < mt) ? mt : mp - st;
            end
            on = note_valid && note_on && (velocity != 0);
            if (on) begin
                rt_left  = held_act ? RT_LEN : 0;
                held_act = 1;
                mheld    = int'(note_num);
                mt  = map_note(int'(note_num), 0, 59, 0) * 256;
                mt1 = map_note(int'(note_num), 0, 59, 1) * 256;
                mt2 = (map_note(int'(note_num), 12, 59, 1) - 12) * 256;
            end else if (note_valid && int'(note_num) == mheld && held_act) begin
                held_act = 0;
                rt_left  = 0;
            end else if (rt_left > 0) begin
                rt_left--;
            end
            e.gate   = held_act && (rt_left == 0);
            e.busy   = (mp != mt);
            e.cv     = mcv;
            e.pitch  = 14'(mp);
            e.target = 14'(mt);
            e.t1     = 14'(mt1);
            e.t2     = 14'(mt2);
            e.tick   = tk;
            q.push_back(e);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t m;
        if (q.size() > 0) begin
            m = q.pop_front();
            chk("gate", gate0, m.gate);
            chk("busy", busy0, m.busy);
            chk("cv_p", cvp0, m.cv);
            chk("cv_n", cvn0, !m.cv);
            chk("pitch", dut0.pitch, m.pitch);
            chk("target", dut0.target, m.target);
            chk("target_fold", dut1.target, m.t1);
            chk("target_fold_lo12", dut2.target, m.t2);
            if (m.tick) begin
                tick_seen++;
                if (cvp0) hi_seen++;
            end
        end
    end

    task automatic ev(input bit on, input int n, input int vel);
        @(negedge clk);
        note_valid = 1'b1;
        note_on    = on;
        note_num   = 7'(n);
        velocity   = 7'(vel);
        @(negedge clk);
        note_valid = 1'b0;
    endtask

    task automatic count_glide(input string nm, input int exp_steps);
        logic [13:0] prev;
        int          steps;
        bit          done;
        chk({nm, "_busy_start"}, busy0, 1'b1);
        prev = dut0.pitch; steps = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (dut0.pitch != prev) steps++;
            prev = dut0.pitch;
            if (!busy0) done = 1;
        end
        if (!done) timeout(nm);
        chk({nm, "_steps"}, steps, exp_steps);
        chk({nm, "_final"}, dut0.pitch, 14'h0A00);
    endtask

    initial begin : stim
        int t0, h0, lo, last_on, hcnt;
        #1500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0, h0, lo, last_on, hcnt;
        repeat (3) @(negedge clk);
        chk("rst_gate", gate0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_cv_p", cvp0, 1'b0);
        chk("rst_cv_n", cvn0, 1'b1);
        chk("rst_pitch", dut0.pitch, 14'h0);
        chk("rst_target", dut0.target, 14'h0);
        reset_n = 1'b1;

        // Clamp to 59 and DSM density
        ev(1, 60, 100);
        chk("on60_gate", gate0, 1'b1);
        chk("on60_target", dut0.target, 14'h3B00);
        repeat (10) @(negedge clk);
        chk("on60_pitch", dut0.pitch, 14'h3B00);
        #1;
        t0 = tick_seen; h0 = hi_seen;
        for (int i = 0; i < 16384 * D + 50 && tick_seen - t0 < 16384; i++) begin
            @(negedge clk);
            #1;
        end
        if (tick_seen - t0 < 16384) timeout("dsm_ticks");
        hcnt = hi_seen - h0;
        n_chk++;
        if (hcnt < 15103 || hcnt > 15105) begin
            n_fail++;
            $display("FAIL dsm_density: actual %0d required 15104+-1", hcnt);
        end

        // Octave fold on the two fold-mode instances
        ev(1, 62, 100);
        chk("fold62", dut1.target, 14'h3200);
        repeat (20) @(negedge clk);
        ev(1, 5, 100);
        chk("fold5_lo12", dut2.target, 14'h0500);
        repeat (20) @(negedge clk);

        // Legato retrigger and note-off matching
        ev(1, 40, 100);
        repeat (20) @(negedge clk);
        ev(1, 45, 100);
        lo = 0;
        while (gate0 == 1'b0 && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        chk("retrig_low_cycles", lo, RT_LEN);
        ev(0, 40, 0);
        chk("off40_ignored", gate0, 1'b1);
        ev(0, 45, 64);
        chk("off45_gate", gate0, 1'b0);

        // Glide at rate 255 (exact) and 254 (final step saturates)
        glide_en = 1'b0;
        ev(1, 0, 100);
        repeat (10) @(negedge clk);
        glide_en = 1'b1; glide_rate = 8'd255;
        ev(1, 10, 100);
        count_glide("glide255", 10);
        glide_en = 1'b0;
        ev(1, 0, 100);
        repeat (10) @(negedge clk);
        glide_en = 1'b1; glide_rate = 8'd254;
        ev(1, 10, 100);
        count_glide("glide254", 11);

        // Velocity-0 note-on acts as note-off, pitch holds
        glide_en = 1'b0;
        ev(1, 30, 100);
        repeat (30) @(negedge clk);
        ev(1, 30, 0);
        chk("vel0_gate", gate0, 1'b0);
        chk("vel0_pitch", dut0.pitch, 14'h1E00);
        repeat (10) @(negedge clk);
        chk("vel0_pitch_hold", dut0.pitch, 14'h1E00);

        // Reset in the middle of a glide and a retrigger
        glide_en = 1'b1; glide_rate = 8'd0;
        ev(1, 40, 100);
        repeat (20) @(negedge clk);
        ev(1, 45, 100);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_gate", gate0, 1'b0);
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_cv_p", cvp0, 1'b0);
        chk("mid_rst_cv_n", cvn0, 1'b1);
        chk("mid_rst_pitch", dut0.pitch, 14'h0);
        chk("mid_rst_cnt", dut0.tick_cnt, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("release_cnt", dut0.tick_cnt, 0);

        // Random traffic against the model
        last_on = 0;
        for (int i = 0; i < 400; i++) begin
            int n, vel;
            bit on;
            repeat ($urandom_range(0, 30)) @(negedge clk);
            glide_en   = 1'($urandom_range(0, 1));
            glide_rate = 8'($urandom_range(0, 255));
            on  = ($urandom_range(0, 2) != 0);
            n   = (!on && $urandom_range(0, 1) == 1) ? last_on : int'($urandom_range(0, 127));
            vel = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 127));
            if (on && vel != 0) last_on = n;
            ev(on, n, vel);
        end
        repeat (50) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/note_cv_out.md
Name: note_cv_out

Overview:
Parametrised monophonic note-to-CV output stage. It sits after the MIDI parser and poly-to-mono stage and drives the differential sigma-delta pitch CV pins. It generalises the fixed clamp-to-59, 6-bit, 1 MHz output path. New features: configurable note range with clamp or octave-fold, fractional pitch with glide (portamento), a gate output with retrigger, and an internal DSM tick divider.

Parameters:
CLK_DIV, 50, clk cycles per DSM/pitch tick (50 MHz / 50 = 1 MHz); legal range >= 2.
NOTE_LO, 0, lowest note mapped to code 0.
NOTE_HI, 59, highest note mapped; NOTE_HI - NOTE_LO must be >= 11 and < 2^CODE_W.
RANGE_MODE, 0, 0 = clamp out-of-range notes; 1 = fold by octaves (add/subtract 12) into range.
CODE_W, 6, integer pitch code width.
FRAC_W, 8, fractional pitch bits used by glide and DSM.
RETRIG, 16, clk cycles gate is held low on a legato retrigger; 0 = no retrigger.

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
note_valid  in  1  one-cycle event strobe
note_on  in  1  1 = note on, 0 = note off (qualified by note_valid)
note_num  in  7  MIDI note number
velocity  in  7  velocity; note_on with velocity 0 is treated as note off
glide_en  in  1  1 = slew pitch toward target; 0 = jump
glide_rate  in  8  slew step per tick = glide_rate+1 fractional LSBs
gate  out  1  note gate
busy  out  1  1 while pitch != target
cv_p  out  1  DSM output
cv_n  out  1  complement of cv_p

Behaviour:
- Reset (async, any time): tick counter = 0, tick = 0, target = 0, pitch = 0, DSM accumulator = 0, held_note = 0, gate = 0, retrig counter = 0, busy = 0, cv_p = 0, cv_n = 1. Reset mid-glide or mid-retrigger abandons the operation entirely.
- Tick:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - Registered tick pulses for one cycle, the cycle after the counter equals CLK_DIV-1.
- Note on (note_valid & note_on & velocity != 0):
  - held_note <= note_num (raw value).
  - Mapped note m:
    - Clamp mode: m = min(max(note_num, NOTE_LO), NOTE_HI).
    - Fold mode: while m > NOTE_HI subtract 12; while m < NOTE_LO add 12. Folding is computed combinationally, bounded by 11 iterations.
  - target <= (m - NOTE_LO) << FRAC_W, width CODE_W+FRAC_W. Target is registered 1 cycle after note_valid.
- Note off (note_valid & (~note_on | velocity == 0)):
  - If note_num == held_note and gate or retrigger is active: gate <= 0 next cycle and retrigger is cancelled.
  - Otherwise the event is ignored.
  - Target and pitch are unchanged (CV holds last pitch).
- Gate:
  - Note on while gate = 0: gate <= 1 next cycle.
  - Note on while gate = 1 and RETRIG > 0: gate <= 0 for exactly RETRIG cycles, then 1.
  - Note on during a retrigger window restarts the RETRIG count.
  - RETRIG = 0: gate stays 1.
- Pitch (updates only on tick):
  - glide_en = 0: pitch <= target.
  - glide_en = 1: pitch moves toward target by glide_rate+1 and saturates at target (never overshoots).
  - A target change in the same cycle as tick takes effect on the following tick.
  - busy = (pitch != target), registered.
- DSM (first-order, on tick):
  - acc (CODE_W+FRAC_W+1 bits) <= acc[CODE_W+FRAC_W-1:0] + pitch.
  - cv_p <= carry bit; cv_n <= ~carry bit.
  - Outputs change only on tick.
  - Pulse density = pitch / 2^(CODE_W+FRAC_W).
- Simultaneous note_valid and tick: the tick uses the pre-event target; the event is still captured.

Test Plan:
- Reset then note on 60, vel 100, glide_en = 0, defaults:
  - gate = 1 after 1 cycle; target = 59<<8 = 0x3B00.
  - After the next tick, pitch = 0x3B00.
  - Over 16384 ticks, cv_p high count = 15104 (±1); cv_n is always the inverse of cv_p.
- RANGE_MODE = 1, note on 62 → mapped to 50, target 0x3200.
  - Note on 5 with NOTE_LO = 12 → mapped to 17, target 0x0500.
- glide_en = 1, glide_rate = 255, note 0 → 10:
  - pitch rises 256 per tick and reaches 0x0A00 after exactly 10 ticks.
  - busy = 1 during the glide, 0 after.
  - glide_rate = 254 from 0 → 0x0A00: 11 ticks, the last step saturating.
- Legato: note 40 on, then note 45 on → gate low for exactly 16 cycles, then high.
  - Note-off 40 is ignored (gate stays 1); note-off 45 gives gate = 0 the next cycle.
- Note on 30 with velocity 0 while holding 30 → gate = 0; pitch is unchanged.
- Assert reset_n mid-glide and mid-retrigger:
  - All outputs take reset values asynchronously (cv_p = 0, cv_n = 1, gate = 0, busy = 0).
  - The tick counter restarts at 0 on release.
